binconv_controller: RTL

- Sequencer for the combinational binary-convolution datapath, which produces a 4-bit 2x2 result from one 16-bit input tile and one 9-bit weight word.
- Controller reads the tile count, streams input tiles from input SRAM at one tile per cycle, and holds weight memory on the weight word.
- Writes each datapath result back to SRAM.
- Sits between the top-level run/busy handshake and the datapath/SRAM ports.

---
 rtl/binconv_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/binconv_controller.sv
// Sequencer for the binary-convolution datapath: reads the tile count, streams
// tiles from SRAM one per cycle and writes each 4-bit result back to SRAM.
module binconv_controller #(
    parameter int ADDR_W    = 12,
    parameter int CNT_ADDR  = 0,
    parameter int WMEM_ADDR = 0,
    parameter int OUT_BASE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_run,
    output logic              dut_busy,
    input  logic [15:0]       sram_dut_read_data,
    input  logic [3:0]        dp_result,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic              dut_sram_write_enable,
    output logic [15:0]       dut_sram_write_data,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_N = 3'd1,
        LOAD_N  = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_A  = ADDR_W'(CNT_ADDR);
    localparam logic [ADDR_W-1:0] WMEM_A = ADDR_W'(WMEM_ADDR);
    localparam logic [ADDR_W-1:0] OUT_A  = ADDR_W'(OUT_BASE);

    state_t            state, state_next;
    logic [ADDR_W-1:0] rd_addr, rd_addr_next;
    logic [ADDR_W-1:0] wr_addr, wr_addr_next;
    logic [ADDR_W-1:0] n, n_next;
    logic              wr_valid, wr_valid_next;
    logic              busy;

    // The count word is narrower than the SRAM word; the upper bits are ignored.
    logic unused_count_bits;
    assign unused_count_bits = ^sram_dut_read_data[15:ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_addr  <= CNT_A;
            wr_addr  <= OUT_A;
            n        <= '0;
            wr_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rd_addr  <= rd_addr_next;
            wr_addr  <= wr_addr_next;
            n        <= n_next;
            wr_valid <= wr_valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        rd_addr_next  = rd_addr;
        n_next        = n;
        wr_valid_next = 1'b0;
        wr_addr_next  = wr_valid ? wr_addr + 1'b1 : wr_addr;
        busy          = 1'b0;

        case (state)
            IDLE: begin
                if (dut_run) begin
                    state_next   = FETCH_N;
                    rd_addr_next = CNT_A;
                    wr_addr_next = OUT_A;
                end
            end
            FETCH_N: begin
                busy         = 1'b1;
                rd_addr_next = CNT_A;
                state_next   = LOAD_N;
            end
            LOAD_N: begin
                busy   = 1'b1;
                n_next = sram_dut_read_data[ADDR_W-1:0];
                if (sram_dut_read_data[ADDR_W-1:0] == '0) begin
                    state_next = DONE;
                end else begin
                    rd_addr_next = CNT_A + 1'b1;
                    state_next   = STREAM;
                end
            end
            STREAM: begin
                // Every tile address presented here yields a write one cycle later.
                busy          = 1'b1;
                wr_valid_next = 1'b1;
                if (rd_addr == CNT_A + n) begin
                    state_next = DRAIN;
                end else begin
                    rd_addr_next = rd_addr + 1'b1;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                // Wait for run to drop so a held run cannot start a second job.
                if (!dut_run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dut_busy               = busy;
    assign dut_sram_read_address  = rd_addr;
    assign dut_wmem_read_address  = WMEM_A;
    assign dut_sram_write_address = wr_addr;
    assign dut_sram_write_enable  = wr_valid;
    assign dut_sram_write_data    = {12'b0, dp_result};
    assign dbg_state              = state;

endmodule
